// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation-control block and its bench.
// status_t is the externally visible end-of-test code; state_t is the internal FSM.
package sim_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_HALT    = 3'd4,
    ST_TIMEOUT = 3'd5
  } status_t;

  typedef enum logic [1:0] {
    S_HOLD = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int unsigned TOHOST_PASS_VALUE = 1;

endpackage

// File: rtl/sim_ctrl_if.sv
// Bundle between the harness (core side) and sim_ctrl.
// i_dm_wen is a one-cycle valid qualifying i_dm_addr/i_dm_wdata; there is no ready, the write is always observed.
interface sim_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  import sim_ctrl_pkg::*;

  logic [XLEN-1:0]  i_pc;
  logic [XLEN-1:0]  i_dm_addr;
  logic [XLEN-1:0]  i_dm_wdata;
  logic             i_dm_wen;

  logic             o_core_rstn;
  logic             o_done;
  logic             o_pass;
  status_t          o_status;
  logic [XLEN-1:0]  o_exit_code;
  logic [CNT_W-1:0] o_cycle_count;
  state_t           dbg_state;

  modport master (
    output i_pc, i_dm_addr, i_dm_wdata, i_dm_wen,
    input  o_core_rstn, o_done, o_pass, o_status, o_exit_code, o_cycle_count, dbg_state
  );

  modport slave (
    input  i_pc, i_dm_addr, i_dm_wdata, i_dm_wen,
    output o_core_rstn, o_done, o_pass, o_status, o_exit_code, o_cycle_count, dbg_state
  );

endinterface

// File: rtl/sim_ctrl_rst_stretch.sv
// Core reset stretcher: asserts asynchronously with rst_n, releases synchronously
// RST_CYCLES edges after rst_n deasserts.
module sim_ctrl_rst_stretch #(
  parameter int RST_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic core_rstn,
  output logic release_now
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;

  logic [CW-1:0] rst_cnt;

  // High on the edge that lifts core_rstn; the FSM enters RUN on the same edge.
  assign release_now = !core_rstn && (rst_cnt == CW'(RST_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt   <= '0;
      core_rstn <= 1'b0;
    end else if (!core_rstn) begin
      if (release_now) begin
        core_rstn <= 1'b1;
      end else begin
        rst_cnt <= rst_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sim_ctrl.sv
// Simulation controller: stretched core reset, PC/tohost monitoring, cycle counting
// and a sticky end-of-test verdict (pass, fail+exit code, halt, timeout).
module sim_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter int              RST_CYCLES  = 4,
  parameter int              STALL_LIMIT = 16,
  parameter int              TIMEOUT     = 100000,
  parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'('h0000_1000)
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  sim_ctrl_if.slave  bus
);

  localparam int SW = (STALL_LIMIT > 2) ? $clog2(STALL_LIMIT) : 1;

  state_t           state_q, state_d;
  status_t          status_q, status_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [XLEN-1:0]  exit_q, exit_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic             first_q, first_d;

  logic core_rstn;
  logic release_now;
  logic ev_tohost;
  logic ev_halt;
  logic ev_timeout;
  logic pc_same;

  sim_ctrl_rst_stretch #(
    .RST_CYCLES (RST_CYCLES)
  ) u_rst_stretch (
    .clk         (i_clk),
    .rst_n       (i_rstn),
    .core_rstn   (core_rstn),
    .release_now (release_now)
  );

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q  <= S_HOLD;
      status_q <= ST_IDLE;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      exit_q   <= '0;
      cyc_q    <= '0;
      pc_q     <= '0;
      stall_q  <= '0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      exit_q   <= exit_d;
      cyc_q    <= cyc_d;
      pc_q     <= pc_d;
      stall_q  <= stall_d;
      first_q  <= first_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    status_d   = status_q;
    done_d     = done_q;
    pass_d     = pass_q;
    exit_d     = exit_q;
    cyc_d      = cyc_q;
    pc_d       = pc_q;
    stall_d    = stall_q;
    first_d    = first_q;
    pc_same    = (bus.i_pc == pc_q);
    ev_tohost  = 1'b0;
    ev_halt    = 1'b0;
    ev_timeout = 1'b0;

    case (state_q)
      S_HOLD: begin
        if (release_now) begin
          state_d  = S_RUN;
          status_d = ST_RUN;
          first_d  = 1'b1;
        end
      end

      S_RUN: begin
        cyc_d   = cyc_q + 1'b1;
        pc_d    = bus.i_pc;
        first_d = 1'b0;
        // pc_q holds nothing meaningful on the first RUN cycle, so it never counts as a repeat.
        stall_d = (first_q || !pc_same) ? '0 : stall_q + 1'b1;

        ev_tohost  = bus.i_dm_wen && (bus.i_dm_addr == TOHOST_ADDR);
        ev_halt    = !first_q && pc_same && (stall_q == SW'(STALL_LIMIT - 2));
        ev_timeout = (cyc_q == CNT_W'(TIMEOUT - 1));

        if (ev_tohost) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          if (bus.i_dm_wdata == XLEN'(TOHOST_PASS_VALUE)) begin
            status_d = ST_PASS;
            pass_d   = 1'b1;
          end else begin
            status_d = ST_FAIL;
            exit_d   = bus.i_dm_wdata >> 1;
          end
        end else if (ev_halt) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_HALT;
        end else if (ev_timeout) begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          status_d = ST_TIMEOUT;
        end
      end

      S_DONE: begin
        // Absorbing: only i_rstn leaves.
      end

      default: begin
        state_d = S_HOLD;
      end
    endcase
  end

  assign bus.o_core_rstn   = core_rstn;
  assign bus.o_done        = done_q;
  assign bus.o_pass        = pass_q;
  assign bus.o_status      = status_q;
  assign bus.o_exit_code   = exit_q;
  assign bus.o_cycle_count = cyc_q;
  assign bus.dbg_state     = state_q;

endmodule

// File: tb/tb_sim_ctrl.sv
// Bench for sim_ctrl: each scenario pushes its expected verdict, and the verdict
// is popped and compared when o_done rises.
module tb_sim_ctrl;
  import sim_ctrl_pkg::*;

  localparam int          XLEN    = 32;
  localparam int          CNT_W   = 32;
  localparam int          W       = 68;
  localparam logic [31:0] TOHOST  = 32'h0000_1000;

  logic clk;
  logic rstn;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp;
  bit           done_seen;
  int           n_cmp;
  int           n_bad;

  sim_ctrl_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  sim_ctrl #(
    .XLEN        (XLEN),
    .CNT_W       (CNT_W),
    .RST_CYCLES  (4),
    .STALL_LIMIT (16),
    .TIMEOUT     (200),
    .TOHOST_ADDR (TOHOST)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] pack_exp(status_t st, logic pass, logic [31:0] exit_code,
                                            logic [31:0] count);
    return {st, pass, exit_code, count};
  endfunction

  task automatic check_outputs(input logic [W-1:0] e);
    check("status",      32'(bus.o_status),   32'(e[67:65]));
    check("pass",        32'(bus.o_pass),     32'(e[64]));
    check("exit_code",   bus.o_exit_code,     e[63:32]);
    check("cycle_count", bus.o_cycle_count,   e[31:0]);
    check("done",        32'(bus.o_done),     32'd1);
  endtask

  task automatic score();
    logic [W-1:0] e;
    check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      last_exp = e;
      check_outputs(e);
    end
  endtask

  // Driver tasks: inputs change #1 after the active edge, outputs are read there too.
  task automatic step(input logic [31:0] pc, input logic wen, input logic [31:0] addr,
                      input logic [31:0] wdata);
    bus.i_pc       = pc;
    bus.i_dm_wen   = wen;
    bus.i_dm_addr  = addr;
    bus.i_dm_wdata = wdata;
    @(posedge clk);
    #1;
    bus.i_dm_wen = 1'b0;
    if (bus.o_done && !done_seen) begin
      done_seen = 1'b1;
      score();
    end
  endtask

  task automatic release_run();
    rstn           = 1'b1;
    // A tohost pass write during the stretch must be ignored.
    bus.i_dm_wen   = 1'b1;
    bus.i_dm_addr  = TOHOST;
    bus.i_dm_wdata = 32'd1;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk);
      #1;
      check("core_rstn_edge", 32'(bus.o_core_rstn), (i == 4) ? 32'd1 : 32'd0);
      check("status_hold",    32'(bus.o_status),    (i == 4) ? 32'(ST_RUN) : 32'(ST_IDLE));
    end
    bus.i_dm_wen = 1'b0;
    check("done_at_run",  32'(bus.o_done),   32'd0);
    check("count_at_run", bus.o_cycle_count, 32'd0);
  endtask

  task automatic check_reset_state();
    check("rst_core_rstn", 32'(bus.o_core_rstn), 32'd0);
    check("rst_done",      32'(bus.o_done),      32'd0);
    check("rst_pass",      32'(bus.o_pass),      32'd0);
    check("rst_status",    32'(bus.o_status),    32'(ST_IDLE));
    check("rst_exit",      bus.o_exit_code,      32'd0);
    check("rst_count",     bus.o_cycle_count,    32'd0);
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    bus.i_pc       = '0;
    bus.i_dm_addr  = '0;
    bus.i_dm_wdata = '0;
    bus.i_dm_wen   = 1'b0;
    done_seen      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    release_run();
  endtask

  task automatic check_done_seen(input string tag);
    check(tag, 32'(done_seen), 32'd1);
  endtask

  // After the verdict, further tohost writes (either value) must change nothing.
  task automatic check_frozen();
    step(32'h0000_0100, 1'b1, TOHOST, 32'd1);
    step(32'h0000_0104, 1'b1, TOHOST, 32'd9);
    step(32'h0000_0108, 1'b0, 32'd0, 32'd0);
    check_outputs(last_exp);
    check("frozen_core_rstn", 32'(bus.o_core_rstn), 32'd1);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    done_seen      = 1'b0;
    last_exp       = '0;
    rstn           = 1'b0;
    bus.i_pc       = '0;
    bus.i_dm_addr  = '0;
    bus.i_dm_wdata = '0;
    bus.i_dm_wen   = 1'b0;

    // Pass at run cycle 50; a write to a neighbouring address earlier is ignored.
    do_reset();
    exp_q.push_back(pack_exp(ST_PASS, 1'b1, 32'd0, 32'd51));
    for (int c = 0; c < 60 && !done_seen; c++) begin
      if (c == 20)      step(32'(4 * c), 1'b1, TOHOST + 32'd4, 32'd1);
      else if (c == 50) step(32'(4 * c), 1'b1, TOHOST, 32'd1);
      else              step(32'(4 * c), 1'b0, 32'd0, 32'd0);
    end
    check_done_seen("pass_done_seen");
    check_frozen();

    // Fail with wdata 7 -> exit code 3, at run cycle 10.
    do_reset();
    exp_q.push_back(pack_exp(ST_FAIL, 1'b0, 32'd3, 32'd11));
    for (int c = 0; c < 30 && !done_seen; c++) begin
      if (c == 10) step(32'(4 * c), 1'b1, TOHOST, 32'd7);
      else         step(32'(4 * c), 1'b0, 32'd0, 32'd0);
    end
    check_done_seen("fail_done_seen");
    check_frozen();

    // Halt: 15 equal samples at 0x20 do not halt; 16 at 0x40 (cycles 30..45) do.
    do_reset();
    exp_q.push_back(pack_exp(ST_HALT, 1'b0, 32'd0, 32'd46));
    for (int c = 0; c < 70 && !done_seen; c++) begin
      logic [31:0] pc;
      if (c < 8)       pc = 32'(4 * c);
      else if (c < 23) pc = 32'h20;
      else if (c < 30) pc = 32'h20 + 32'(4 * (c - 22));
      else             pc = 32'h40;
      step(pc, 1'b0, 32'd0, 32'd0);
    end
    check_done_seen("halt_done_seen");
    check_frozen();

    // Timeout after 200 run cycles with a moving PC.
    do_reset();
    exp_q.push_back(pack_exp(ST_TIMEOUT, 1'b0, 32'd0, 32'd200));
    for (int c = 0; c < 230 && !done_seen; c++) begin
      step(32'(4 * c), 1'b0, 32'd0, 32'd0);
    end
    check_done_seen("timeout_done_seen");
    check_frozen();

    // Tohost pass on the very cycle the halt condition fires: pass wins.
    do_reset();
    exp_q.push_back(pack_exp(ST_PASS, 1'b1, 32'd0, 32'd16));
    for (int c = 0; c < 40 && !done_seen; c++) begin
      if (c == 15) step(32'h80, 1'b1, TOHOST, 32'd1);
      else         step(32'h80, 1'b0, 32'd0, 32'd0);
    end
    check_done_seen("prio_done_seen");

    // Mid-run reset at cycle 30: async clear, full stretch, counters restart.
    do_reset();
    for (int c = 0; c < 30; c++) begin
      step(32'(4 * c), 1'b0, 32'd0, 32'd0);
    end
    check("midrun_count", bus.o_cycle_count, 32'd30);
    #2;
    rstn = 1'b0;
    #1;
    check_reset_state();
    @(posedge clk);
    #1;
    done_seen = 1'b0;
    release_run();
    exp_q.push_back(pack_exp(ST_FAIL, 1'b0, 32'h7FFF_FFFF, 32'd4));
    for (int c = 0; c < 20 && !done_seen; c++) begin
      if (c == 3) step(32'(4 * c), 1'b1, TOHOST, 32'hFFFF_FFFF);
      else        step(32'(4 * c), 1'b0, 32'd0, 32'd0);
    end
    check_done_seen("restart_done_seen");
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
